// File: rtl/dpram_arb_pkg.sv
// Shared types and constants for the dual-port RAM port arbiter.
package dpram_arb_pkg;

  localparam int unsigned DefNumReq = 4;
  localparam int unsigned DefAw     = 10;
  localparam int unsigned DefDw     = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRdIssue = 2'd1,
    StRdWait  = 2'd2
  } state_e;

  // Width of an encoded requester id; never zero.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dpram_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from i_ptr+1.
module dpram_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_id,
  output logic               o_any
);

  always_comb begin
    int unsigned w_idx;
    w_idx = 0;
    o_gnt = '0;
    o_id  = '0;
    o_any = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = (32'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_id         = w_idx[IW-1:0];
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin sequencer sharing one synchronous RAM port among NUM_REQ requesters.
// Optional write-protect window enabled by defining DPRAM_ARB_WPROT_EN.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned AW      = DefAw,
  parameter int unsigned DW      = DefDw
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata
`ifdef DPRAM_ARB_WPROT_EN
  ,
  input  logic                  wprot_on,
  input  logic [AW-1:0]         wprot_lo,
  input  logic [AW-1:0]         wprot_hi,
  output logic                  wr_err
`endif
);

  localparam int unsigned IW = id_width(NUM_REQ);

  state_e               r_state, w_state_d;
  logic [IW-1:0]        r_ptr, r_id;
  logic                 r_mem_en, r_mem_we;
  logic [AW-1:0]        r_mem_addr;
  logic [DW-1:0]        r_mem_wdata;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [DW-1:0]        r_rsp_rdata;

  logic [NUM_REQ-1:0]   w_gnt;
  logic [IW-1:0]        w_win_id;
  logic                 w_any, w_idle, w_hs, w_wblock;
  logic                 w_win_we;
  logic [AW-1:0]        w_win_addr;
  logic [DW-1:0]        w_win_wdata;

  dpram_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_id  (w_win_id),
    .o_any (w_any)
  );

  assign w_idle = (r_state == StIdle);
  assign w_hs   = w_idle && w_any;
  // Ready must also read low while reset is asserted, not just after the next edge.
  assign req_ready = (w_idle && rst_n) ? w_gnt : '0;

  always_comb begin
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_win_we    = req_we[i];
        w_win_addr  = req_addr[i*AW +: AW];
        w_win_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

`ifdef DPRAM_ARB_WPROT_EN
  logic r_wr_err;
  assign w_wblock = wprot_on && (w_win_addr >= wprot_lo) && (w_win_addr <= wprot_hi);
  assign wr_err   = r_wr_err;
`else
  assign w_wblock = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (w_hs && !w_win_we) w_state_d = StRdIssue;
      StRdIssue: w_state_d = StRdWait;
      StRdWait:  w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= IW'(NUM_REQ - 1);
      r_id        <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
`ifdef DPRAM_ARB_WPROT_EN
      r_wr_err    <= 1'b0;
`endif
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_rsp_valid <= '0;
      if (w_hs) begin
        r_ptr <= w_win_id;
        if (w_win_we) begin
          // A protected write is consumed but leaves the RAM slot empty.
          if (!w_wblock) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_win_addr;
            r_mem_wdata <= w_win_wdata;
          end
`ifdef DPRAM_ARB_WPROT_EN
          if (w_wblock) r_wr_err <= 1'b1;
`endif
        end else begin
          r_mem_en   <= 1'b1;
          r_mem_addr <= w_win_addr;
          r_id       <= w_win_id;
        end
      end
      if (r_state == StRdWait) begin
        r_rsp_valid <= NUM_REQ'(1) << r_id;
        r_rsp_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Randomised bench for dpram_port_arbiter against a cycle-scheduled transaction model.
module tb_dpram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_we = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              mem_en, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata = '0;
`ifdef DPRAM_ARB_WPROT_EN
  logic              wprot_on = 1'b0;
  logic [AW-1:0]     wprot_lo = '0;
  logic [AW-1:0]     wprot_hi = '0;
  logic              wr_err;
`endif

  dpram_port_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DPRAM_ARB_WPROT_EN
    ,
    .wprot_on  (wprot_on),
    .wprot_lo  (wprot_lo),
    .wprot_hi  (wprot_hi),
    .wr_err    (wr_err)
`endif
  );

  always #5 clk = ~clk;

  // Physical RAM attached to the port.
  logic [DW-1:0] ram [1<<AW];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: expected contents plus events scheduled by cycle number.
  logic [DW-1:0] ref_ram [1<<AW];
  int            m_cyc, m_ptr, m_busy_until, m_rsp_cyc, m_rsp_id;
  logic [DW-1:0] m_rsp_data, m_last_rdata;
  logic          m_nxt_en, m_nxt_we, m_wr_err;
  logic [AW-1:0] m_nxt_addr;
  logic [DW-1:0] m_nxt_wdata;

  // Pending transaction per requester.
  bit            p_v [N];
  logic          p_we [N];
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_wdata [N];

  int rate = 0, we_pct = 50, drop_pct = 0;

  task automatic model_reset();
    m_cyc = 0; m_ptr = N - 1; m_busy_until = -1; m_rsp_cyc = -1; m_rsp_id = 0;
    m_rsp_data = '0; m_last_rdata = '0; m_nxt_en = 1'b0; m_nxt_we = 1'b0;
    m_nxt_addr = '0; m_nxt_wdata = '0; m_wr_err = 1'b0;
    for (int i = 0; i < N; i++) p_v[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '1;
    req_we = '0;
    #1;
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
`ifdef DPRAM_ARB_WPROT_EN
    check_eq("rst_wr_err", wr_err, 0);
`endif
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    p_v[i] = 1'b1; p_we[i] = we; p_addr[i] = a; p_wdata[i] = d;
  endtask

  task automatic step();
    logic [N-1:0] exp_gnt, exp_rsp;
    int           win;
    bit           prot;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = p_v[i];
      req_we[i]             = p_we[i];
      req_addr[i*AW +: AW]  = p_addr[i];
      req_wdata[i*DW +: DW] = p_wdata[i];
    end
    #1;
    exp_gnt = '0;
    win = -1;
    if (m_cyc > m_busy_until) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (win < 0 && p_v[j]) win = j;
      end
    end
    if (win >= 0) exp_gnt[win] = 1'b1;
    check_eq("req_ready", req_ready, exp_gnt);
    check_eq("mem_en", mem_en, m_nxt_en);
    if (m_nxt_en) begin
      check_eq("mem_we", mem_we, m_nxt_we);
      check_eq("mem_addr", mem_addr, m_nxt_addr);
      if (m_nxt_we) check_eq("mem_wdata", mem_wdata, m_nxt_wdata);
    end
    exp_rsp = '0;
    if (m_rsp_cyc == m_cyc) begin
      exp_rsp[m_rsp_id] = 1'b1;
      m_last_rdata = m_rsp_data;
    end
    check_eq("rsp_valid", rsp_valid, exp_rsp);
    check_eq("rsp_rdata", rsp_rdata, m_last_rdata);
`ifdef DPRAM_ARB_WPROT_EN
    check_eq("wr_err", wr_err, m_wr_err);
`endif

    m_nxt_en = 1'b0;
    if (win >= 0) begin
      m_ptr = win;
      p_v[win] = 1'b0;
      if (p_we[win]) begin
        prot = 1'b0;
`ifdef DPRAM_ARB_WPROT_EN
        prot = wprot_on && (p_addr[win] >= wprot_lo) && (p_addr[win] <= wprot_hi);
        if (prot) m_wr_err = 1'b1;
`endif
        if (!prot) begin
          m_nxt_en = 1'b1; m_nxt_we = 1'b1;
          m_nxt_addr = p_addr[win]; m_nxt_wdata = p_wdata[win];
          ref_ram[p_addr[win]] = p_wdata[win];
        end
      end else begin
        m_nxt_en = 1'b1; m_nxt_we = 1'b0; m_nxt_addr = p_addr[win];
        m_busy_until = m_cyc + 2;
        m_rsp_cyc = m_cyc + 3;
        m_rsp_id = win;
        m_rsp_data = ref_ram[p_addr[win]];
      end
    end
    m_cyc++;

    for (int i = 0; i < N; i++) begin
      if (!p_v[i]) begin
        if (rate > 0 && $urandom_range(0, 99) < rate)
          set_req(i, ($urandom_range(0, 99) < we_pct), AW'($urandom_range(0, 15)),
                  DW'($urandom));
      end else if ($urandom_range(0, 99) < drop_pct) begin
        p_v[i] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = DW'($urandom);
      ref_ram[i] = ram[i];
    end
    model_reset();
    do_reset();

    // Single write, then a read of the same location.
    rate = 0;
    set_req(2, 1'b1, 10'h005, 8'hA5);
    repeat (2) step();
    set_req(1, 1'b0, 10'h005, 8'h00);
    repeat (5) step();

    // Every requester writing back-to-back: strict rotation, no bubbles.
    rate = 100; we_pct = 100; drop_pct = 0;
    repeat (24) step();
    rate = 0;
    repeat (3) step();

    // Simultaneous read and write out of reset.
    do_reset();
    set_req(0, 1'b0, 10'h005, 8'h00);
    set_req(3, 1'b1, 10'h009, 8'h3C);
    repeat (6) step();

    // Reset while the read sits in its wait cycle.
    set_req(1, 1'b0, 10'h005, 8'h00);
    repeat (2) step();
    do_reset();
    repeat (3) step();
    set_req(0, 1'b0, 10'h009, 8'h00);
    repeat (5) step();

    // Mixed random traffic with withdrawals.
    rate = 60; we_pct = 50; drop_pct = 5;
    repeat (400) step();
    rate = 70; we_pct = 20; drop_pct = 0;
    repeat (200) step();

`ifdef DPRAM_ARB_WPROT_EN
    rate = 0;
    repeat (4) step();
    wprot_on = 1'b1; wprot_lo = 10'h100; wprot_hi = 10'h1FF;
    set_req(0, 1'b1, 10'h180, 8'h11);
    repeat (2) step();
    set_req(1, 1'b1, 10'h200, 8'h22);
    repeat (2) step();
    set_req(2, 1'b0, 10'h180, 8'h00);
    repeat (4) step();
    wprot_lo = 10'h004; wprot_hi = 10'h007;
    rate = 60; we_pct = 60; drop_pct = 5;
    repeat (200) step();
`endif

    rate = 0;
    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
